// File: rtl/fft_frame_capture.sv
// Captures one frame of codec samples per start pulse into a register array,
// then streams it to the FFT core over valid/ready with sop/eop markers.
module fft_frame_capture #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned FRAME_LEN = 256,
    parameter int unsigned ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_i,
    input  logic [DATA_W-1:0] sample_in_i,
    input  logic              sample_valid_i,
    output logic [DATA_W-1:0] fft_data_o,
    output logic              fft_valid_o,
    output logic              fft_sop_o,
    output logic              fft_eop_o,
    input  logic              fft_ready_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              start_ignored_o
);

    typedef enum logic [1:0] {StIdle, StCapture, StStream} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FRAME_LEN - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic                frame_done_q;
    logic                start_ignored_q;
    logic [DATA_W-1:0]   mem_q [FRAME_LEN];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= StIdle;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            frame_done_q    <= 1'b0;
            start_ignored_q <= 1'b0;
        end else begin
            frame_done_q    <= 1'b0;
            start_ignored_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A sample strobe coincident with start is deliberately not captured.
                    if (start_i) begin
                        state_q  <= StCapture;
                        wr_ptr_q <= '0;
                    end
                end
                StCapture: begin
                    start_ignored_q <= start_i;
                    if (sample_valid_i) begin
                        if (wr_ptr_q == LastAddr) begin
                            state_q  <= StStream;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                StStream: begin
                    start_ignored_q <= start_i;
                    if (fft_ready_i) begin
                        if (rd_ptr_q == LastAddr) begin
                            state_q      <= StIdle;
                            rd_ptr_q     <= '0;
                            frame_done_q <= 1'b1;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Buffer is intentionally not reset; contents are only observable after a full capture.
    always_ff @(posedge CLK) begin
        if (state_q == StCapture && sample_valid_i) begin
            mem_q[wr_ptr_q] <= sample_in_i;
        end
    end

    always_comb begin
        fft_valid_o     = (state_q == StStream);
        fft_data_o      = mem_q[rd_ptr_q];
        fft_sop_o       = fft_valid_o && (rd_ptr_q == '0);
        fft_eop_o       = fft_valid_o && (rd_ptr_q == LastAddr);
        busy_o          = (state_q != StIdle);
        frame_done_o    = frame_done_q;
        start_ignored_o = start_ignored_q;
    end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Bench for fft_frame_capture: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a frame-level model.
module tb_fft_frame_capture;

    localparam int DW = 24;
    localparam int FL = 8;

    logic          CLK;
    logic          RST;
    logic          start_i;
    logic [DW-1:0] sample_in_i;
    logic          sample_valid_i;
    logic [DW-1:0] fft_data_o;
    logic          fft_valid_o;
    logic          fft_sop_o;
    logic          fft_eop_o;
    logic          fft_ready_i;
    logic          busy_o;
    logic          frame_done_o;
    logic          start_ignored_o;

    fft_frame_capture #(
        .DATA_W   (DW),
        .FRAME_LEN(FL),
        .ADDR_W   (3)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .start_i        (start_i),
        .sample_in_i    (sample_in_i),
        .sample_valid_i (sample_valid_i),
        .fft_data_o     (fft_data_o),
        .fft_valid_o    (fft_valid_o),
        .fft_sop_o      (fft_sop_o),
        .fft_eop_o      (fft_eop_o),
        .fft_ready_i    (fft_ready_i),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .start_ignored_o(start_ignored_o)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame-level model: idle / capturing a list of samples / streaming that list.
    int            m_mode;   // 0 idle, 1 capture, 2 stream
    logic [DW-1:0] m_frame[$];
    int            m_idx;
    bit            m_done, m_ign, m_known;

    function automatic void model_edge(input logic rst, st, sv, input logic [DW-1:0] smp,
                                       input logic rdy);
        bit nd, ni;
        nd = 0;
        ni = 0;
        if (rst) begin
            m_mode  = 0;
            m_idx   = 0;
            m_frame.delete();
            m_known = 1;
        end else if (m_mode == 0) begin
            if (st) begin
                m_mode = 1;
                m_frame.delete();
            end
        end else if (m_mode == 1) begin
            ni = st;
            if (sv) m_frame.push_back(smp);
            if (m_frame.size() == FL) begin
                m_mode = 2;
                m_idx  = 0;
            end
        end else begin
            ni = st;
            if (rdy) begin
                if (m_idx == FL - 1) begin
                    m_mode = 0;
                    nd     = 1;
                end else begin
                    m_idx++;
                end
            end
        end
        m_done = nd;
        m_ign  = ni;
    endfunction

    // Observations sampled at the falling edge of the most recent step.
    logic          s_valid, s_sop, s_eop, s_busy, s_done, s_ign;
    logic [DW-1:0] s_data;
    logic [DW-1:0] acc_q[$];
    int            done_cnt, ign_cnt, valid_cnt;

    task automatic step(input logic rst, st, sv, input logic [DW-1:0] smp, input logic rdy);
        RST            = rst;
        start_i        = st;
        sample_valid_i = sv;
        sample_in_i    = smp;
        fft_ready_i    = rdy;
        @(negedge CLK);
        s_valid = fft_valid_o;
        s_data  = fft_data_o;
        s_sop   = fft_sop_o;
        s_eop   = fft_eop_o;
        s_busy  = busy_o;
        s_done  = frame_done_o;
        s_ign   = start_ignored_o;
        if (m_known) begin
            chk("busy", 32'(s_busy), 32'(m_mode != 0));
            chk("fft_valid", 32'(s_valid), 32'(m_mode == 2));
            chk("frame_done", 32'(s_done), 32'(m_done));
            chk("start_ignored", 32'(s_ign), 32'(m_ign));
            if (m_mode == 2) begin
                chk("fft_data", 32'(s_data), 32'(m_frame[m_idx]));
                chk("fft_sop", 32'(s_sop), 32'(m_idx == 0));
                chk("fft_eop", 32'(s_eop), 32'(m_idx == FL - 1));
            end
        end
        if (s_valid === 1'b1 && rdy) acc_q.push_back(s_data);
        if (s_valid === 1'b1) valid_cnt++;
        if (s_done === 1'b1) done_cnt++;
        if (s_ign === 1'b1) ign_cnt++;
        @(posedge CLK);
        model_edge(rst, st, sv, smp, rdy);
        #1;
    endtask

    task automatic clear_obs();
        acc_q.delete();
        done_cnt  = 0;
        ign_cnt   = 0;
        valid_cnt = 0;
    endtask

    task automatic chk_acc(input string name, input logic [DW-1:0] exp[$]);
        chk({name, "_count"}, 32'(acc_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
            chk(name, 32'(acc_q[i]), 32'(exp[i]));
    endtask

    typedef struct {
        logic          chk;
        logic          rst, st, sv;
        logic [DW-1:0] smp;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] ed;
        logic          esop, eeop, ebusy, edone;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic c, r, s, v, input logic [DW-1:0] d, input logic rd,
                                input logic ev, input logic [DW-1:0] ed,
                                input logic es, ee, eb, edn);
        vec_t x;
        x = '{c, r, s, v, d, rd, ev, ed, es, ee, eb, edn};
        tbl.push_back(x);
    endfunction

    logic [DW-1:0] exp_q[$];

    initial begin
        m_known = 0;
        m_mode  = 0;
        m_done  = 0;
        m_ign   = 0;
        m_idx   = 0;
        RST = 1'b1; start_i = 1'b0; sample_valid_i = 1'b0; sample_in_i = '0; fft_ready_i = 1'b1;
        @(posedge CLK);
        #1;

        // 1. Basic frame of 1..8 with ready held high.
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= FL; i++) add(1, 0, 0, 1, DW'(i), 1, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= FL; i++)
            add(1, 0, 0, 0, 0, 1, 1, DW'(i), logic'(i == 1), logic'(i == FL), 1, 0);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        clear_obs();
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].rst, tbl[k].st, tbl[k].sv, tbl[k].smp, tbl[k].rdy);
            if (tbl[k].chk) begin
                chk("t1_valid", 32'(s_valid), 32'(tbl[k].ev));
                chk("t1_busy", 32'(s_busy), 32'(tbl[k].ebusy));
                chk("t1_done", 32'(s_done), 32'(tbl[k].edone));
                if (tbl[k].ev) begin
                    chk("t1_data", 32'(s_data), 32'(tbl[k].ed));
                    chk("t1_sop", 32'(s_sop), 32'(tbl[k].esop));
                    chk("t1_eop", 32'(s_eop), 32'(tbl[k].eeop));
                end
            end
        end

        // 2. Negative full-scale samples with ready toggling; each held until accepted.
        clear_obs();
        exp_q.delete();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < FL; i++) begin
            exp_q.push_back(DW'(24'h800000 + i));
            step(0, 0, 1, DW'(24'h800000 + i), 0);
        end
        for (int n = 0; n < 2 * FL; n++) step(0, 0, 0, 0, logic'(n % 2));
        step(0, 0, 0, 0, 1);
        chk_acc("t2_data", exp_q);
        chk("t2_stream_cycles", 32'(valid_cnt), 32'(2 * FL));
        chk("t2_done_cnt", 32'(done_cnt), 1);

        // 3. Strobe coincident with start is not captured.
        clear_obs();
        exp_q.delete();
        step(0, 1, 1, DW'(100), 1);
        for (int i = 1; i <= FL; i++) begin
            exp_q.push_back(DW'(100 + i));
            step(0, 0, 1, DW'(100 + i), 1);
        end
        for (int n = 0; n < FL + 2; n++) step(0, 0, 0, 0, 1);
        chk_acc("t3_data", exp_q);

        // 4. Start while capturing and while streaming.
        clear_obs();
        exp_q.delete();
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < FL; i++) begin
            exp_q.push_back(DW'(24'h5A0000 + i));
            step(0, 0, 1, DW'(24'h5A0000 + i), 1);
            if (i == 2) step(0, 1, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        for (int n = 0; n < FL + 2; n++) step(0, 0, 0, 0, 1);
        chk_acc("t4_data", exp_q);
        chk("t4_ignored_cnt", 32'(ign_cnt), 2);
        chk("t4_done_cnt", 32'(done_cnt), 1);

        // 5. Reset after the 5th sample discards the partial frame.
        clear_obs();
        exp_q.delete();
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(24'h111100 + i), 1);
        step(1, 0, 0, 0, 1);
        for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 1);
        chk("t5_valid_before_new", 32'(valid_cnt), 0);
        step(0, 1, 0, 0, 1);
        for (int i = 0; i < FL; i++) begin
            exp_q.push_back(DW'(24'hABC000 + i));
            step(0, 0, 1, DW'(24'hABC000 + i), 1);
        end
        for (int n = 0; n < FL + 2; n++) step(0, 0, 0, 0, 1);
        chk_acc("t5_data", exp_q);
        chk("t5_done_cnt", 32'(done_cnt), 1);

        // 6. Back-to-back: start lands in the frame_done cycle.
        clear_obs();
        exp_q.delete();
        step(0, 1, 0, 0, 1);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FL; i++) begin
                exp_q.push_back(DW'(24'h300000 + 16 * f + i));
                step(0, 0, 1, DW'(24'h300000 + 16 * f + i), 1);
            end
            for (int n = 0; n < FL; n++) step(0, 0, 0, 0, 1);
            step(0, logic'(f == 0), 0, 0, 1);
            chk("t6_done_at_start", 32'(s_done), 1);
        end
        step(0, 0, 0, 0, 1);
        chk_acc("t6_data", exp_q);
        chk("t6_ignored_cnt", 32'(ign_cnt), 0);
        chk("t6_done_cnt", 32'(done_cnt), 2);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 1)), DW'($urandom), logic'($urandom_range(0, 9) < 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
